// File: rtl/mem_access_unit_pkg.sv
// mem_access_pkg: shared types and constants for mem_access_unit.
// Optional watchdog build macro: MEM_ACCESS_TIMEOUT_EN.
package mem_access_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Access size from kind and func3; low two bits carry the size.
    function automatic size_e acc_size(input logic fetch,
                                       input logic [2:0] f3);
        size_e sz;
        sz = SZ_W;
        if (!fetch) begin
            unique case (f3[1:0])
                F3_SB[1:0]: sz = SZ_B;
                F3_SH[1:0]: sz = SZ_H;
                F3_SW[1:0]: sz = SZ_W;
                default:    sz = SZ_W;
            endcase
        end
        return sz;
    endfunction

    function automatic logic is_aligned(input size_e sz,
                                        input logic [1:0] lo);
        logic ok;
        unique case (sz)
            SZ_B:    ok = 1'b1;
            SZ_H:    ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Unified memory bus between mem_access_unit (master) and memory (slave).
// Ready/valid with arbitrary wait states.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic              bus_ready;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the byte/half lane of a read word and extends it.
// Purely combinational.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] ext
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select and sign/zero extension by func3.
    always_comb begin
        byte_lane = bus_rdata[8*addr_lo +: 8];
        half_lane = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (func3)
            F3_LB:   ext = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   ext = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  ext = {24'd0, byte_lane};
            F3_LHU:  ext = {16'd0, half_lane};
            F3_LW:   ext = bus_rdata;
            default: ext = bus_rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: multicycle fetch/load/store engine holding IR, OldPC, MDR.
// Define MEM_ACCESS_TIMEOUT_EN to build the bus watchdog.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              ir_write,
    input  logic              mem_write,
    input  logic              adr_src,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [2:0]        func3,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] old_pc,
    output logic [6:0]        opcode,
    output logic [2:0]        rd_func3,
    output logic [6:0]        func7,
    output logic [31:0]       mdr,
    mem_access_unit_if.master bus
);
    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic              fetch_q, fetch_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] old_pc_q, old_pc_d;
    logic [31:0]       mdr_q, mdr_d;
    logic              valid_q, valid_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       bwdata_q, bwdata_d;
    logic [3:0]        wstrb_q, wstrb_d;

    logic [ADDR_W-1:0] addr_sel;
    logic              store_in;
    size_e             size_in;
    logic [3:0]        strb_in;
    logic [31:0]       wdat_in;
    logic [31:0]       ext_data;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = (CW > 8) ? CW : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    load_extend u_ext (
        .bus_rdata (bus.bus_rdata),
        .addr_lo   (lo_q),
        .func3     (f3_q),
        .ext       (ext_data)
    );

    // Request decode: address, size, store lanes and data.
    always_comb begin
        addr_sel = (ir_write || !adr_src) ? pc : data_addr;
        store_in = mem_write & ~ir_write;
        size_in  = acc_size(ir_write, func3);
        unique case (size_in)
            SZ_B: begin
                strb_in = 4'b0001 << addr_sel[1:0];
                wdat_in = {4{wdata[7:0]}};
            end
            SZ_H: begin
                strb_in = 4'b0011 << addr_sel[1:0];
                wdat_in = {2{wdata[15:0]}};
            end
            default: begin
                strb_in = 4'b1111;
                wdat_in = wdata;
            end
        endcase
    end

    // Next-state and register updates for the IDLE/BUS/DONE sequence.
    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        fault_d  = fault_q;
        fetch_d  = fetch_q;
        store_d  = store_q;
        f3_d     = f3_q;
        lo_d     = lo_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        old_pc_d = old_pc_q;
        mdr_d    = mdr_q;
        valid_d  = valid_q;
        we_d     = we_q;
        addr_d   = addr_q;
        bwdata_d = bwdata_q;
        wstrb_d  = wstrb_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    fetch_d  = ir_write;
                    store_d  = store_in;
                    f3_d     = func3;
                    lo_d     = addr_sel[1:0];
                    pc_d     = pc;
                    addr_d   = {addr_sel[ADDR_W-1:2], 2'b00};
                    bwdata_d = wdat_in;
                    if (is_aligned(size_in, addr_sel[1:0])) begin
                        state_d = ST_BUS;
                        busy_d  = 1'b1;
                        fault_d = 1'b0;
                        valid_d = 1'b1;
                        we_d    = store_in;
                        wstrb_d = store_in ? strb_in : 4'b0000;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end
                end
            end
            ST_BUS: begin
                if (bus.bus_ready) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                    if (fetch_q) begin
                        ir_d     = bus.bus_rdata;
                        old_pc_d = pc_q;
                    end else if (!store_q) begin
                        mdr_d = ext_data;
                    end
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    fault_d = 1'b1;
                    valid_d = 1'b0;
                    we_d    = 1'b0;
                    wstrb_d = 4'b0000;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            fetch_q  <= 1'b0;
            store_q  <= 1'b0;
            f3_q     <= 3'd0;
            lo_q     <= 2'd0;
            pc_q     <= '0;
            ir_q     <= NOP_INSTR;
            old_pc_q <= '0;
            mdr_q    <= 32'd0;
            valid_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            bwdata_q <= 32'd0;
            wstrb_q  <= 4'd0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            fetch_q  <= fetch_d;
            store_q  <= store_d;
            f3_q     <= f3_d;
            lo_q     <= lo_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            old_pc_q <= old_pc_d;
            mdr_q    <= mdr_d;
            valid_q  <= valid_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            bwdata_q <= bwdata_d;
            wstrb_q  <= wstrb_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign instr         = ir_q;
    assign old_pc        = old_pc_q;
    assign opcode        = ir_q[6:0];
    assign rd_func3      = ir_q[14:12];
    assign func7         = ir_q[31:25];
    assign mdr           = mdr_q;
    assign bus.bus_valid = valid_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = bwdata_q;
    assign bus.bus_wstrb = wstrb_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Random and directed checks of mem_access_unit against a behavioural model.
// Define MEM_ACCESS_TIMEOUT_EN to also exercise the watchdog.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req, ir_write, mem_write, adr_src;
    logic [31:0] pc, data_addr, wdata;
    logic [2:0]  func3;
    logic        busy, done, fault;
    logic [31:0] instr, old_pc, mdr;
    logic [6:0]  opcode, func7;
    logic [2:0]  rd_func3;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] m_ir, m_oldpc, m_mdr;
    logic        m_fault;

    mem_access_unit_if #(.ADDR_W(32)) bus_if ();

    mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ir_write  (ir_write),
        .mem_write (mem_write),
        .adr_src   (adr_src),
        .pc        (pc),
        .data_addr (data_addr),
        .func3     (func3),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .instr     (instr),
        .old_pc    (old_pc),
        .opcode    (opcode),
        .rd_func3  (rd_func3),
        .func7     (func7),
        .mdr       (mdr),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] rd,
                                             input logic [1:0] lo,
                                             input logic [2:0] f3);
        logic [31:0] v;
        v = rd >> (8 * lo);
        case (f3)
            3'd0: begin
                v = v % 256;
                if (v >= 128) v = v - 256;
            end
            3'd1: begin
                v = v % 65536;
                if (v >= 32768) v = v - 65536;
            end
            3'd4: v = v % 256;
            3'd5: v = v % 65536;
            default: v = rd;
        endcase
        return v;
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, "_instr"}, instr, m_ir);
        chk({tag, "_oldpc"}, old_pc, m_oldpc);
        chk({tag, "_mdr"}, mdr, m_mdr);
        chk({tag, "_opcode"}, 32'(opcode), 32'(m_ir[6:0]));
        chk({tag, "_f3"}, 32'(rd_func3), 32'(m_ir[14:12]));
        chk({tag, "_f7"}, 32'(func7), 32'(m_ir[31:25]));
        chk({tag, "_fault"}, 32'(fault), 32'(m_fault));
    endtask

    // One full access from an IDLE cycle back to the next IDLE cycle.
    task automatic access(input bit fetch, input bit mw, input bit src,
                          input logic [31:0] p, input logic [31:0] da,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd);
        logic [31:0] a, ew;
        logic [3:0]  es;
        int          nbytes;
        bit          ok, st;
        st = mw && !fetch;
        a  = (fetch || !src) ? p : da;
        if (fetch || f3[1] || f3[1:0] == 2'b11) nbytes = 4;
        else nbytes = (f3[1:0] == 2'b00) ? 1 : 2;
        ok = (a % nbytes) == 0;
        es = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (st && b >= int'(a[1:0]) && b < int'(a[1:0]) + nbytes)
                es[b] = 1'b1;
        if (nbytes == 1) ew = wd[7:0] * 32'h0101_0101;
        else if (nbytes == 2) ew = wd[15:0] * 32'h0001_0001;
        else ew = wd;

        req = 1'b1; ir_write = fetch; mem_write = mw; adr_src = src;
        pc = p; data_addr = da; func3 = f3; wdata = wd;
        bus_if.bus_ready = 1'($urandom_range(0, 1));
        step();
        req = 1'b0;
        pc = $urandom; data_addr = $urandom; wdata = $urandom;
        func3 = 3'($urandom);
        if (!ok) begin
            m_fault = 1'b1;
            chk("mis_done", 32'(done), 32'd1);
            chk("mis_valid", 32'(bus_if.bus_valid), 32'd0);
            chk("mis_busy", 32'(busy), 32'd0);
        end else begin
            chk("c1_valid", 32'(bus_if.bus_valid), 32'd1);
            chk("c1_busy", 32'(busy), 32'd1);
            chk("c1_done", 32'(done), 32'd0);
            chk("c1_addr", bus_if.bus_addr, a & ~32'd3);
            chk("c1_we", 32'(bus_if.bus_we), 32'(st));
            chk("c1_wstrb", 32'(bus_if.bus_wstrb), 32'(es));
            if (st) chk("c1_wdata", bus_if.bus_wdata, ew);
            for (int i = 0; i < waits; i++) begin
                req = 1'($urandom_range(0, 1));
                bus_if.bus_ready = 1'b0;
                bus_if.bus_rdata = $urandom;
                step();
                chk("w_valid", 32'(bus_if.bus_valid), 32'd1);
                chk("w_addr", bus_if.bus_addr, a & ~32'd3);
                chk("w_done", 32'(done), 32'd0);
            end
            req = 1'($urandom_range(0, 1));
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = rd;
            step();
            bus_if.bus_ready = 1'b0;
            m_fault = 1'b0;
            if (fetch) begin
                m_ir = rd;
                m_oldpc = p;
            end else if (!st) begin
                m_mdr = ref_load(rd, a[1:0], f3);
            end
            chk("d_done", 32'(done), 32'd1);
            chk("d_busy", 32'(busy), 32'd0);
            chk("d_valid", 32'(bus_if.bus_valid), 32'd0);
        end
        chk_regs("acc");
        req = 1'b0;
        bus_if.bus_ready = 1'($urandom_range(0, 1));
        step();
        chk("idle_done", 32'(done), 32'd0);
        bus_if.bus_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; ir_write = 1'b0; mem_write = 1'b0;
        adr_src = 1'b0; pc = '0; data_addr = '0; func3 = '0; wdata = '0;
        bus_if.bus_ready = 1'b0; bus_if.bus_rdata = '0;
        m_ir = 32'h0000_0013; m_oldpc = '0; m_mdr = '0; m_fault = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_regs("rst");
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rst_we", 32'(bus_if.bus_we), 32'd0);
        chk("rst_wstrb", 32'(bus_if.bus_wstrb), 32'd0);
        chk("rst_addr", bus_if.bus_addr, 32'd0);
        chk("rst_wdata", bus_if.bus_wdata, 32'd0);

        access(1, 0, 0, 32'h100, 32'h0, 3'd2, 32'h0, 3, 32'h00A0_0093);
        chk("fetch_instr", instr, 32'h00A0_0093);
        chk("fetch_opc", 32'(opcode), 32'h13);
        chk("fetch_oldpc", old_pc, 32'h100);

        access(0, 0, 1, 32'h40, 32'h203, 3'd0, 32'h0, 0, 32'h80FF_1234);
        chk("lb_mdr", mdr, 32'hFFFF_FF80);
        access(0, 0, 1, 32'h40, 32'h203, 3'd4, 32'h0, 0, 32'h80FF_1234);
        chk("lbu_mdr", mdr, 32'h0000_0080);

        access(0, 1, 1, 32'h44, 32'h402, 3'd1, 32'h0000_BEEF, 1,
               32'h1234_5678);
        access(0, 0, 1, 32'h48, 32'h005, 3'd2, 32'h0, 0, 32'h0);
        chk("mis_fault", 32'(fault), 32'd1);
        access(0, 0, 1, 32'h4C, 32'h008, 3'd2, 32'h0, 0, 32'hCAFE_F00D);
        chk("clr_fault", 32'(fault), 32'd0);

        // Reset while the bus is stalled.
        req = 1'b1; ir_write = 1'b1; mem_write = 1'b0; pc = 32'h300;
        step();
        req = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_ir = 32'h0000_0013; m_oldpc = '0; m_mdr = '0; m_fault = 1'b0;
        chk("rb_valid", 32'(bus_if.bus_valid), 32'd0);
        chk("rb_busy", 32'(busy), 32'd0);
        chk("rb_done", 32'(done), 32'd0);
        chk_regs("rb");
        step();
        chk("rb_done2", 32'(done), 32'd0);

        for (int n = 0; n < 300; n++) begin
            int          k;
            logic [31:0] p, da;
            k  = $urandom_range(0, 2);
            p  = $urandom & 32'h0000_FFFC;
            if ($urandom_range(0, 3) == 0) p = p | 32'($urandom_range(0, 3));
            da = $urandom & 32'h0000_FFFF;
`ifdef MEM_ACCESS_TIMEOUT_EN
            access(k == 0, k == 1 || (k == 0 && $urandom_range(0, 1) == 1),
                   1'($urandom_range(0, 1)), p, da, 3'($urandom),
                   $urandom, $urandom_range(0, 3), $urandom);
`else
            access(k == 0, k == 1 || (k == 0 && $urandom_range(0, 1) == 1),
                   1'($urandom_range(0, 1)), p, da, 3'($urandom),
                   $urandom, $urandom_range(0, 6), $urandom);
`endif
        end

`ifdef MEM_ACCESS_TIMEOUT_EN
        req = 1'b1; ir_write = 1'b0; mem_write = 1'b0; adr_src = 1'b1;
        data_addr = 32'h500; func3 = 3'd2;
        step();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_valid", 32'(bus_if.bus_valid), 32'd1);
            chk("to_done", 32'(done), 32'd0);
            step();
        end
        m_fault = 1'b1;
        chk("to_done_end", 32'(done), 32'd1);
        chk("to_valid_end", 32'(bus_if.bus_valid), 32'd0);
        chk_regs("to");
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multicycle memory access unit sitting between the multicycle controller and the unified instruction/data memory bus. It accepts one access request per instruction step from the controller, performs a ready/valid bus transaction with arbitrary wait states, and holds the results in architectural registers. Fetched words go to the instruction register (IR) with the PC of that instruction (OldPC), and loads go to the memory data register (MDR) after byte/half extraction and extension. It reports `busy` back to the controller so the controller holds its state while the bus stalls.

## Interface
- `ADDR_W`, 32: address width.
- `TIMEOUT_CYCLES`, 255: watchdog limit, used only with the timeout feature.
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 1: start an access. Sampled only in IDLE.
- `ir_write` in 1: the access is an instruction fetch. It uses `pc` and loads IR/OldPC.
- `mem_write` in 1: the access is a store. Ignored when `ir_write`=1.
- `adr_src` in 1: address select for non-fetch accesses. 0 selects `pc`, 1 selects `data_addr`.
- `pc` in ADDR_W: current PC.
- `data_addr` in ADDR_W: ALU-computed load/store address.
- `func3` in 3: access size/sign, using the RV32I load/store encoding.
- `wdata` in 32: store data from rs2.
- `busy` out 1: high from the cycle after an accepted `req` until the cycle before `done`.
- `done` out 1: one-cycle pulse when the access completes.
- `fault` out 1: sticky error flag (misaligned address, or timeout). Cleared by `reset` or by the next accepted `req`.
- `instr` out 32: IR.
- `old_pc` out ADDR_W: PC of the instruction in IR.
- `opcode` out 7: combinational slice `instr[6:0]`.
- `rd_func3` out 3: combinational slice `instr[14:12]`.
- `func7` out 7: combinational slice `instr[31:25]`.
- `mdr` out 32: extended load data.
- `bus_valid` out 1: bus request valid.
- `bus_we` out 1: bus write enable.
- `bus_addr` out ADDR_W: word-aligned bus address.
- `bus_wdata` out 32: bus write data.
- `bus_wstrb` out 4: bus byte write strobes.
- `bus_ready` in 1: bus accepts/completes the request.
- `bus_rdata` in 32: bus read data.

## Operation
- **States**:
  - IDLE → on `req`: latch the address, kind, `func3`, `wdata` and `pc`. If misaligned, go to DONE with `fault`=1 and no bus cycle; otherwise go to BUS.
  - BUS → on `bus_ready`: go to DONE.
  - DONE → IDLE unconditionally.
- **Address**: fetch address is `pc`; otherwise `adr_src ? data_addr : pc`.
- **Alignment rules**:
  - A fetch or word access requires `addr[1:0]`=0.
  - A half access requires `addr[0]`=0.
  - A byte access is always aligned.
- **Bus address**: `{addr[ADDR_W-1:2],2'b00}`.
- **Bus signals**: `bus_valid`, `bus_addr`, `bus_we`, `bus_wdata` and `bus_wstrb` are registered and stay constant for the whole of BUS.
- **Store strobes**: SB is `4'b0001<<addr[1:0]`; SH is `4'b0011<<addr[1:0]`; SW is `4'b1111`.
- **Store data**: the byte is replicated ×4 and the half ×2.
- **Reads**: `bus_wstrb`=0 and `bus_we`=0.
- **Fetch completion**: on `bus_ready` in BUS, fetch writes IR←`bus_rdata` and OldPC←latched `pc`.
- **Load completion**: on `bus_ready` in BUS, load writes MDR←extended lane:
  - LB 000 and LH 001 are sign-extended.
  - LW 010 is the full word.
  - LBU 100 and LHU 101 are zero-extended.
  - Encodings 011, 110 and 111 are treated as LW.
- **Stores**: update neither IR nor MDR.
- **Faulted access**: updates no register except `fault`.
- **`req` outside IDLE**: ignored, with no queueing.
- **Reset values**:
  - IR is 32'h00000013 (NOP).
  - OldPC and MDR are 0.
  - `fault`, `busy`, `done`, `bus_valid`, `bus_we` are 0.
  - `bus_wstrb`, `bus_addr` and `bus_wdata` are 0.
  - State is IDLE.
- **Reset during BUS**: `bus_valid` drops at the next edge, with no completion and no register update.

## Timing
- Cycle 0: `req` sampled in IDLE.
- Cycle 1: `bus_valid`=1 and `busy`=1.
- Cycle k (k≥1): the first cycle with `bus_ready`=1 completes the transfer.
- Cycle k+1: `done`=1, `busy`=0, and IR/MDR show the new value.
- Minimum latency is 2 cycles from `req` to `done`.
- A misaligned `req` at cycle 0 gives `done`=1 and `fault`=1 at cycle 1.
- `bus_ready` outside BUS is ignored.
- A `bus_ready` that is already high at cycle 1 completes immediately.

## Configuration
- **Macro**: `MEM_ACCESS_TIMEOUT_EN`.
- **Defined**: an 8+ bit counter clears on entry to BUS and counts each BUS cycle without `bus_ready`. Reaching `TIMEOUT_CYCLES` drops `bus_valid`, sets `fault` and goes to DONE with no register update.
- **Undefined**: no counter is built, and BUS waits indefinitely.

## Structure
- **Package `mem_access_pkg`**:
  - state enum (IDLE, BUS, DONE);
  - `func3` size codes (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - NOP constant 32'h00000013.
- **Sub-module `load_extend`**: combinational. Inputs are `bus_rdata`, `addr[1:0]` and `func3`; output is the 32-bit extended value.

## Test plan
- Fetch from `pc`=0x100, `bus_ready` after 3 wait cycles, `bus_rdata`=0x00A00093:
  - `done` 5 cycles after `req`;
  - `instr`=0x00A00093, `opcode`=0x13, `old_pc`=0x100.
- LB from `data_addr`=0x203 with `adr_src`=1, `bus_rdata`=0x80FF1234, `bus_ready` immediate:
  - `bus_addr`=0x200;
  - `mdr`=0xFFFFFF80 after 2 cycles. The same access as LBU gives `mdr`=0x00000080.
- SH at 0x0402, `wdata`=0x0000BEEF:
  - `bus_we`=1, `bus_wstrb`=4'b1100, `bus_wdata`=0xBEEFBEEF;
  - `mdr` and `instr` unchanged.
- LW at 0x0005:
  - no `bus_valid`;
  - `done` and `fault`=1 one cycle after `req`.
  - A following aligned `req` clears `fault`.
- `reset` asserted during BUS while `bus_ready`=0:
  - next cycle `bus_valid`=0, `instr`=0x00000013, `busy`=0, and no `done`.
  - With `MEM_ACCESS_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, holding `bus_ready`=0 gives `fault`=1 and `done` after 4 BUS cycles.
